// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller and the PC register block.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_FLUSH     = 2'd2,
    ST_HALT      = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_VEC = 32'h0000_0014;

endpackage

// File: rtl/pc_fetch_wait_cnt.sv
// Load wait counter: cleared on load issue, counts LOAD_WAIT cycles and flags
// the cycle in which the next count value reaches MAX_WAIT-1.
module pc_fetch_wait_cnt #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d   = cnt_q + CW'(1);
      timeout = (cnt_d == CW'(MAX_WAIT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing controller: PC stall, delayed PC for the branch adder, flush on
// taken redirects, load-latency absorption with timeout, and halt handling.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_VEC,
  parameter int          MAX_WAIT = 8,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc,
  input  logic             load_issue,
  input  logic             dmem_rvalid,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_stall,
  output logic [31:0]      pc_delayed,
  output logic             flush,
  output logic             instr_valid,
  output logic             halted,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] stall_count
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_delayed_q, pc_delayed_d;
  logic             flush_q, flush_d;
  logic             instr_valid_q, instr_valid_d;
  logic             halted_q, halted_d;
  logic             wait_timeout_q, wait_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             wait_hit;

  pc_fetch_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_RUN),
    .inc     (state_q == ST_LOAD_WAIT),
    .timeout (wait_hit)
  );

  // Decoded from state and control inputs only, never from pc.
  always_comb begin
    pc_stall = (state_q == ST_LOAD_WAIT) || (state_q == ST_HALT) ||
               ((state_q == ST_RUN) && (halt_req || (load_issue && !branch_taken)));
  end

  always_comb begin
    state_d        = state_q;
    wait_timeout_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_req)          state_d = ST_HALT;
        else if (branch_taken) state_d = ST_FLUSH;
        else if (load_issue)   state_d = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (dmem_rvalid) begin
          state_d = ST_RUN;
        end else if (wait_hit) begin
          state_d        = ST_RUN;
          wait_timeout_d = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT: begin
        if (resume && !halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    pc_delayed_d  = pc_stall ? pc_delayed_q : pc;
    flush_d       = (state_d == ST_FLUSH);
    halted_d      = (state_d == ST_HALT);
    instr_valid_d = (state_d != ST_FLUSH) && (state_d != ST_HALT);
    stall_count_d = stall_count_q + (pc_stall ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_delayed_q   <= RESET_PC;
      flush_q        <= 1'b0;
      instr_valid_q  <= 1'b0;
      halted_q       <= 1'b0;
      wait_timeout_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_delayed_q   <= pc_delayed_d;
      flush_q        <= flush_d;
      instr_valid_q  <= instr_valid_d;
      halted_q       <= halted_d;
      wait_timeout_q <= wait_timeout_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign pc_delayed   = pc_delayed_q;
  assign flush        = flush_q;
  assign instr_valid  = instr_valid_q;
  assign halted       = halted_q;
  assign wait_timeout = wait_timeout_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; a second instance with a 4-bit stall counter
// shares the stimulus to exercise counter wrap.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = 32'h14;
  logic        load_issue = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic        branch_taken = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;

  logic        pc_stall, flush, instr_valid, halted, wait_timeout;
  logic [31:0] pc_delayed, stall_count;
  logic        w_pc_stall, w_flush, w_instr_valid, w_halted, w_wait_timeout;
  logic [31:0] w_pc_delayed;
  logic [3:0]  w_stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(32'h14), .MAX_WAIT(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .load_issue(load_issue),
    .dmem_rvalid(dmem_rvalid), .branch_taken(branch_taken), .halt_req(halt_req),
    .resume(resume), .pc_stall(pc_stall), .pc_delayed(pc_delayed), .flush(flush),
    .instr_valid(instr_valid), .halted(halted), .wait_timeout(wait_timeout),
    .stall_count(stall_count)
  );

  pc_fetch_ctrl #(.RESET_PC(32'h14), .MAX_WAIT(8), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .pc(pc), .load_issue(load_issue),
    .dmem_rvalid(dmem_rvalid), .branch_taken(branch_taken), .halt_req(halt_req),
    .resume(resume), .pc_stall(w_pc_stall), .pc_delayed(w_pc_delayed), .flush(w_flush),
    .instr_valid(w_instr_valid), .halted(w_halted), .wait_timeout(w_wait_timeout),
    .stall_count(w_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset asserted between clock edges
    #7 rst_n = 1'b0;
    #1;
    chk("rst_pc_delayed", pc_delayed, 32'h14);
    chk("rst_pc_stall", {31'b0, pc_stall}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_timeout", {31'b0, wait_timeout}, 32'h0);
    chk("rst_stall_count", stall_count, 32'h0);
    chk("rst_w_outputs", {w_pc_stall, w_flush, w_instr_valid, w_halted, w_wait_timeout},
        32'h0);
    chk("rst_w_pc_delayed", w_pc_delayed, 32'h14);
    chk("rst_w_stall_count", {28'b0, w_stall_count}, 32'h0);
    #22 rst_n = 1'b1;

    // PC follows one cycle behind
    tick();
    chk("first_instr_valid", {31'b0, instr_valid}, 32'h1);
    chk("pcd_0x14", pc_delayed, 32'h14);
    pc = 32'h18;
    tick();
    chk("pcd_0x18", pc_delayed, 32'h18);
    pc = 32'h20;
    tick();
    chk("pcd_0x20", pc_delayed, 32'h20);

    // Load with one-cycle data latency
    pc = 32'h24; load_issue = 1'b1;
    #1 chk("load_issue_stall", {31'b0, pc_stall}, 32'h1);
    tick();
    load_issue = 1'b0; dmem_rvalid = 1'b1;
    #1 chk("load_wait_stall", {31'b0, pc_stall}, 32'h1);
    chk("load_pcd_hold", pc_delayed, 32'h20);
    tick();
    dmem_rvalid = 1'b0;
    chk("load_pcd_hold2", pc_delayed, 32'h20);
    chk("load_stall_count", stall_count, 32'd2);
    #1 chk("load_done_nostall", {31'b0, pc_stall}, 32'h0);
    tick();
    chk("pcd_0x24", pc_delayed, 32'h24);

    // Load timeout: pulse 8 cycles after issue
    pc = 32'h28; load_issue = 1'b1;
    tick();
    load_issue = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("to_wait_pulse_%0d", i), {31'b0, wait_timeout}, 32'h0);
      #1 chk($sformatf("to_wait_stall_%0d", i), {31'b0, pc_stall}, 32'h1);
      tick();
    end
    chk("to_pulse", {31'b0, wait_timeout}, 32'h1);
    chk("to_stall_count", stall_count, 32'd10);
    #1 chk("to_run_nostall", {31'b0, pc_stall}, 32'h0);
    tick();
    chk("to_pulse_end", {31'b0, wait_timeout}, 32'h0);

    // Taken branch with simultaneous load
    pc = 32'h30; branch_taken = 1'b1; load_issue = 1'b1;
    #1 chk("br_nostall", {31'b0, pc_stall}, 32'h0);
    tick();
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_instr_invalid", {31'b0, instr_valid}, 32'h0);
    chk("br_pcd", pc_delayed, 32'h30);
    pc = 32'h80; load_issue = 1'b0;
    #1 chk("br_flush_nostall", {31'b0, pc_stall}, 32'h0);
    tick();
    branch_taken = 1'b0;
    chk("br_flush_end", {31'b0, flush}, 32'h0);
    chk("br_instr_valid", {31'b0, instr_valid}, 32'h1);
    chk("br_pcd_0x80", pc_delayed, 32'h80);
    chk("br_stall_count", stall_count, 32'd10);

    // Halt request deferred behind an outstanding load
    pc = 32'h84; load_issue = 1'b1;
    tick();
    load_issue = 1'b0; halt_req = 1'b1;
    chk("hl_not_halted_a", {31'b0, halted}, 32'h0);
    tick();
    dmem_rvalid = 1'b1;
    chk("hl_not_halted_b", {31'b0, halted}, 32'h0);
    tick();
    dmem_rvalid = 1'b0;
    chk("hl_not_halted_c", {31'b0, halted}, 32'h0);
    #1 chk("hl_req_stall", {31'b0, pc_stall}, 32'h1);
    tick();
    chk("hl_halted", {31'b0, halted}, 32'h1);
    chk("hl_instr_invalid", {31'b0, instr_valid}, 32'h0);
    resume = 1'b1;
    tick();
    chk("hl_resume_ignored", {31'b0, halted}, 32'h1);
    resume = 1'b0; halt_req = 1'b0;
    tick();
    chk("hl_still_halted", {31'b0, halted}, 32'h1);
    resume = 1'b1;
    #1 chk("hl_stall", {31'b0, pc_stall}, 32'h1);
    tick();
    resume = 1'b0;
    chk("hl_released", {31'b0, halted}, 32'h0);
    chk("hl_instr_valid", {31'b0, instr_valid}, 32'h1);
    #1 chk("hl_run_nostall", {31'b0, pc_stall}, 32'h0);
    chk("stall_count_17", stall_count, 32'd17);
    chk("w_stall_count_wrap", {28'b0, w_stall_count}, 32'h1);

    // Asynchronous reset in the middle of a load wait
    pc = 32'h88; load_issue = 1'b1;
    tick();
    load_issue = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pcd", pc_delayed, 32'h14);
    chk("arst_stall", {31'b0, pc_stall}, 32'h0);
    chk("arst_stall_count", stall_count, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("arst_no_pulse_%0d", i), {31'b0, wait_timeout}, 32'h0);
    end
    chk("arst_w_stall_count", {28'b0, w_stall_count}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
